// File: rtl/psum_accumulator.sv
// Accumulates convolution partial sums over input channels in a line buffer.
// The final channel pass adds bias, applies ReLU, rounds, shifts and saturates.
module psum_accumulator #(
  parameter int DATA_INTER_WIDTH = 24,
  parameter int DATA_ACC_WIDTH   = 32,
  parameter int DATA_ACT_WIDTH   = 12,
  parameter int LINE_MAX         = 64,
  parameter int CH_MAX           = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(LINE_MAX):0]          cfg_line_len,
  input  logic [$clog2(CH_MAX):0]            cfg_ch_num,
  input  logic [4:0]                         cfg_shift,
  input  logic                               cfg_relu,
  input  logic signed [DATA_ACC_WIDTH-1:0]   bias,
  input  logic signed [DATA_INTER_WIDTH-1:0] inter_data,
  input  logic                               inter_valid,
  output logic signed [DATA_ACT_WIDTH-1:0]   act_data,
  output logic                               act_valid,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int LW  = $clog2(LINE_MAX) + 1;
  localparam int CW  = $clog2(CH_MAX) + 1;
  localparam int AW  = $clog2(LINE_MAX);
  localparam int ACC = DATA_ACC_WIDTH;
  localparam int ACT = DATA_ACT_WIDTH;

  localparam logic signed [ACC:0] ACT_MAX = {{(ACC-ACT+2){1'b0}}, {(ACT-1){1'b1}}};
  localparam logic signed [ACC:0] ACT_MIN = {{(ACC-ACT+2){1'b1}}, {(ACT-1){1'b0}}};

  typedef enum logic {S_IDLE, S_ACC} state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          line_len_q, line_len_d;
  logic [CW-1:0]          ch_num_q, ch_num_d;
  logic [4:0]             shift_q, shift_d;
  logic                   relu_q, relu_d;
  logic signed [ACC-1:0]  bias_q, bias_d;
  logic [LW-1:0]          x_cnt_q, x_cnt_d;
  logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
  logic signed [ACT-1:0]  act_data_q, act_data_d;
  logic                   act_valid_q, act_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   fwd_vld_q, fwd_vld_d;
  logic [AW-1:0]          fwd_addr_q, fwd_addr_d;
  logic signed [ACC-1:0]  fwd_data_q, fwd_data_d;

  logic signed [ACC-1:0]  line_buf [LINE_MAX];

  logic                   accept_start, beat, x_last, ch_first, ch_last;
  logic [AW-1:0]          x_idx;
  logic signed [ACC-1:0]  in_ext, rd_word, base, sum, relu_sum;
  logic signed [ACC:0]    ext, rnd, rounded, shifted;
  logic signed [ACT-1:0]  sat;

  always_comb begin
    accept_start = start && (state_q == S_IDLE) && !busy_q;
    beat         = inter_valid && (state_q == S_ACC);
    x_idx        = x_cnt_q[AW-1:0];
    x_last       = (x_cnt_q == line_len_q - LW'(1));
    ch_first     = (ch_cnt_q == '0);
    ch_last      = (ch_cnt_q == ch_num_q - CW'(1));
    in_ext       = {{(ACC-DATA_INTER_WIDTH){inter_data[DATA_INTER_WIDTH-1]}}, inter_data};
    // Single-pixel rows revisit the same word every beat; bypass the last write.
    rd_word      = (fwd_vld_q && fwd_addr_q == x_idx) ? fwd_data_q : line_buf[x_idx];
    base         = ch_first ? bias_q : rd_word;
    sum          = base + in_ext;

    relu_sum = (relu_q && sum[ACC-1]) ? '0 : sum;
    ext      = {relu_sum[ACC-1], relu_sum};
    rnd      = ({{ACC{1'b0}}, 1'b1} << shift_q) >> 1;
    rounded  = ext + rnd;
    shifted  = rounded >>> shift_q;
    if (shifted > ACT_MAX)      sat = ACT_MAX[ACT-1:0];
    else if (shifted < ACT_MIN) sat = ACT_MIN[ACT-1:0];
    else                        sat = shifted[ACT-1:0];
  end

  // NOTE: every next-state signal takes its hold value first, so no path through
  // this block leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    line_len_d  = line_len_q;
    ch_num_d    = ch_num_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    bias_d      = bias_q;
    x_cnt_d     = x_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    act_data_d  = act_data_q;
    act_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    fwd_vld_d   = fwd_vld_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;

    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (inter_valid) begin
          err_d = 1'b1;
        end else if (accept_start) begin
          err_d = 1'b0;
        end
        if (accept_start) begin
          state_d    = S_ACC;
          line_len_d = cfg_line_len;
          ch_num_d   = cfg_ch_num;
          shift_d    = cfg_shift;
          relu_d     = cfg_relu;
          bias_d     = bias;
          x_cnt_d    = '0;
          ch_cnt_d   = '0;
          busy_d     = 1'b1;
          fwd_vld_d  = 1'b0;
        end
      end
      S_ACC: begin
        if (beat) begin
          fwd_vld_d  = 1'b1;
          fwd_addr_d = x_idx;
          fwd_data_d = sum;
          if (ch_last) begin
            act_valid_d = 1'b1;
            act_data_d  = sat;
          end
          if (x_last) begin
            x_cnt_d  = '0;
            ch_cnt_d = ch_cnt_q + CW'(1);
            if (ch_last) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            x_cnt_d = x_cnt_q + LW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_len_q  <= '0;
      ch_num_q    <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      bias_q      <= '0;
      x_cnt_q     <= '0;
      ch_cnt_q    <= '0;
      act_data_q  <= '0;
      act_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fwd_vld_q   <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_len_q  <= line_len_d;
      ch_num_q    <= ch_num_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      bias_q      <= bias_d;
      x_cnt_q     <= x_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      act_data_q  <= act_data_d;
      act_valid_q <= act_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fwd_vld_q   <= fwd_vld_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // NOTE: the line buffer has no reset so it maps onto RAM; channel 0 of every
  // job overwrites each word before it is read.
  always_ff @(posedge clk) begin
    if (beat) line_buf[x_idx] <= sum;
  end

  assign act_data  = act_data_q;
  assign act_valid = act_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator: one task per scenario,
// expected activations hand-computed from the bias/ReLU/round/shift/saturate rules.
module tb_psum_accumulator;

  logic               clk, rst, start;
  logic [6:0]         cfg_line_len;
  logic [8:0]         cfg_ch_num;
  logic [4:0]         cfg_shift;
  logic               cfg_relu;
  logic signed [31:0] bias;
  logic signed [23:0] inter_data;
  logic               inter_valid;
  logic signed [11:0] act_data;
  logic               act_valid, busy, done, err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  psum_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_line_len (cfg_line_len),
    .cfg_ch_num   (cfg_ch_num),
    .cfg_shift    (cfg_shift),
    .cfg_relu     (cfg_relu),
    .bias         (bias),
    .inter_data   (inter_data),
    .inter_valid  (inter_valid),
    .act_data     (act_data),
    .act_valid    (act_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle(input int n);
    inter_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Config inputs are scrambled after the start cycle to show they were latched.
  task automatic start_job(input int line, input int ch, input int sh, input bit relu_en,
                           input int b);
    start        = 1'b1;
    cfg_line_len = 7'(line);
    cfg_ch_num   = 9'(ch);
    cfg_shift    = 5'(sh);
    cfg_relu     = relu_en;
    bias         = b;
    @(posedge clk);
    #1;
    start        = 1'b0;
    cfg_line_len = 7'd5;
    cfg_ch_num   = 9'd7;
    cfg_shift    = 5'd9;
    cfg_relu     = ~relu_en;
    bias         = -12345;
  endtask

  task automatic beat(input int d);
    inter_valid = 1'b1;
    inter_data  = 24'(d);
    @(posedge clk);
    #1;
    inter_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; inter_valid = 1'b0; inter_data = '0;
    cfg_line_len = '0; cfg_ch_num = '0; cfg_shift = '0; cfg_relu = 1'b0; bias = '0;
    #12;
    total_cnt++;
    if (act_data !== 12'sd0 || act_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_state: got d=%0d v=%b busy=%b done=%b err=%b, expected all 0",
               act_data, act_valid, busy, done, err);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle(1);
  endtask

  task automatic test_single_channel;
    int vin[4] = '{1, -2, 3, 2047};
    start_job(4, 1, 0, 1'b0, 0);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL single_busy_on: got %b, expected 1", busy);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      beat(vin[i]);
      total_cnt++;
      if (act_valid !== 1'b1 || act_data !== 12'(vin[i]) || done !== (i == 3) || busy !== 1'b1)
        $display("FAIL single_act[%0d]: got v=%b d=%0d done=%b busy=%b, expected v=1 d=%0d done=%b busy=1",
                 i, act_valid, act_data, done, busy, vin[i], (i == 3));
      else pass_cnt++;
    end
    drive_idle(1);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || act_valid !== 1'b0 || act_data !== 12'sd2047)
      $display("FAIL single_end: got busy=%b done=%b v=%b d=%0d, expected busy=0 done=0 v=0 d=2047",
               busy, done, act_valid, act_data);
    else pass_cnt++;
    drive_idle(1);
  endtask

  task automatic test_multi_channel;
    start_job(3, 3, 0, 1'b0, 10);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 3; i++) begin
        beat(5 + i);
        total_cnt++;
        if (p < 2) begin
          if (act_valid !== 1'b0)
            $display("FAIL multi_quiet[%0d][%0d]: got v=%b, expected v=0", p, i, act_valid);
          else pass_cnt++;
        end else begin
          if (act_valid !== 1'b1 || act_data !== 12'(3 * (5 + i) + 10) || done !== (i == 2))
            $display("FAIL multi_act[%0d]: got v=%b d=%0d done=%b, expected v=1 d=%0d done=%b",
                     i, act_valid, act_data, done, 3 * (5 + i) + 10, (i == 2));
          else pass_cnt++;
        end
      end
      drive_idle(1);
    end
    drive_idle(1);
  endtask

  task automatic test_round_shift;
    int vin[4] = '{40, -40, 0, 7};
    int exp_act[2] = '{3, -2};
    start_job(2, 2, 4, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      beat(vin[i]);
      total_cnt++;
      if (i < 2) begin
        if (act_valid !== 1'b0) $display("FAIL shift_quiet[%0d]: got v=%b, expected v=0", i, act_valid);
        else pass_cnt++;
      end else begin
        if (act_valid !== 1'b1 || act_data !== 12'(exp_act[i-2]))
          $display("FAIL shift_act[%0d]: got v=%b d=%0d, expected v=1 d=%0d",
                   i - 2, act_valid, act_data, exp_act[i-2]);
        else pass_cnt++;
      end
    end
    drive_idle(2);
  endtask

  task automatic test_sat_relu;
    for (int r = 0; r < 2; r++) begin
      start_job(2, 1, 0, r[0], 0);
      beat(5000);
      total_cnt++;
      if (act_valid !== 1'b1 || act_data !== 12'sd2047)
        $display("FAIL sat_pos[relu=%0d]: got v=%b d=%0d, expected v=1 d=2047", r, act_valid, act_data);
      else pass_cnt++;
      beat(-5000);
      total_cnt++;
      if (act_valid !== 1'b1 || act_data !== (r == 1 ? 12'sd0 : -12'sd2048))
        $display("FAIL sat_neg[relu=%0d]: got v=%b d=%0d, expected v=1 d=%0d",
                 r, act_valid, act_data, (r == 1) ? 0 : -2048);
      else pass_cnt++;
      drive_idle(2);
    end
  endtask

  task automatic test_forwarding;
    for (int g = 0; g < 2; g++) begin
      start_job(1, 4, 0, 1'b0, 1);
      for (int i = 0; i < 4; i++) begin
        if (g == 1 && i > 0) drive_idle($urandom_range(1, 3));
        beat(1);
        total_cnt++;
        if (i < 3) begin
          if (act_valid !== 1'b0)
            $display("FAIL fwd_quiet[gap=%0d][%0d]: got v=%b, expected v=0", g, i, act_valid);
          else pass_cnt++;
        end else begin
          if (act_valid !== 1'b1 || act_data !== 12'sd5 || done !== 1'b1)
            $display("FAIL fwd_act[gap=%0d]: got v=%b d=%0d done=%b, expected v=1 d=5 done=1",
                     g, act_valid, act_data, done);
          else pass_cnt++;
        end
      end
      drive_idle(2);
    end
  endtask

  task automatic test_idle_err;
    beat(77);
    total_cnt++;
    if (err !== 1'b1 || act_valid !== 1'b0)
      $display("FAIL idle_err_set: got err=%b v=%b, expected err=1 v=0", err, act_valid);
    else pass_cnt++;
    drive_idle(1);
    total_cnt++;
    if (err !== 1'b1 || act_valid !== 1'b0)
      $display("FAIL idle_err_sticky: got err=%b v=%b, expected err=1 v=0", err, act_valid);
    else pass_cnt++;
    start_job(1, 1, 0, 1'b0, 0);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL idle_err_clear: got err=%b, expected 0", err);
    else pass_cnt++;
    beat(-3);
    total_cnt++;
    if (act_valid !== 1'b1 || act_data !== -12'sd3)
      $display("FAIL idle_err_job: got v=%b d=%0d, expected v=1 d=-3", act_valid, act_data);
    else pass_cnt++;
    drive_idle(2);
  endtask

  task automatic test_start_ignored;
    start_job(2, 1, 0, 1'b0, 0);
    beat(100);
    total_cnt++;
    if (act_valid !== 1'b1 || act_data !== 12'sd100 || done !== 1'b0)
      $display("FAIL restart_first: got v=%b d=%0d done=%b, expected v=1 d=100 done=0",
               act_valid, act_data, done);
    else pass_cnt++;
    start = 1'b1; cfg_line_len = 7'd4; cfg_ch_num = 9'd3; cfg_shift = 5'd3; cfg_relu = 1'b1; bias = 500;
    @(posedge clk);
    #1;
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL restart_busy: got %b, expected 1", busy);
    else pass_cnt++;
    beat(-7);
    total_cnt++;
    if (act_valid !== 1'b1 || act_data !== -12'sd7 || done !== 1'b1)
      $display("FAIL restart_second: got v=%b d=%0d done=%b, expected v=1 d=-7 done=1",
               act_valid, act_data, done);
    else pass_cnt++;
    drive_idle(2);
  endtask

  task automatic test_reset_mid_job;
    int exp_act[2] = '{4, 6};
    start_job(2, 2, 0, 1'b0, 0);
    beat(3);
    beat(4);
    beat(5);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (act_data !== 12'sd0 || act_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL midreset_outputs: got d=%0d v=%b busy=%b done=%b err=%b, expected all 0",
               act_data, act_valid, busy, done, err);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle(1);
    start_job(2, 2, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      beat(i + 1);
      total_cnt++;
      if (i < 2) begin
        if (act_valid !== 1'b0) $display("FAIL midreset_quiet[%0d]: got v=%b, expected v=0", i, act_valid);
        else pass_cnt++;
      end else begin
        if (act_valid !== 1'b1 || act_data !== 12'(exp_act[i-2]) || done !== (i == 3))
          $display("FAIL midreset_act[%0d]: got v=%b d=%0d done=%b, expected v=1 d=%0d done=%b",
                   i - 2, act_valid, act_data, done, exp_act[i-2], (i == 3));
        else pass_cnt++;
      end
    end
    drive_idle(2);
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_multi_channel();
    test_round_shift();
    test_sat_relu();
    test_forwarding();
    test_idle_err();
    test_start_ignored();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
